// File: rtl/prbs_pkg.sv
// Shared constants and types for the PRBS7 receive checker.
// Stream order: bit 0 of each word is the earliest bit on the wire.
package prbs_pkg;

    localparam int unsigned PRBS_W       = 32;
    localparam int unsigned PRBS7_TAP_A  = 7;
    localparam int unsigned PRBS7_TAP_B  = 6;
    localparam int unsigned PRBS7_PERIOD = 127;

    // Width that holds 0..PRBS_W error bits
    localparam int unsigned POP_W = $clog2(PRBS_W + 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/prbs_popcount32.sv
// Registered population count of the 32-bit per-bit error vector.
module prbs_popcount32
    import prbs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PRBS_W-1:0] vec,
    output logic [POP_W-1:0]  cnt
);

    logic [POP_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < PRBS_W; i++) begin
            sum = sum + POP_W'(vec[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= sum;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS7 checker: predicts every bit from the seven received bits
// before it, then tracks lock and keeps saturating error/word counters.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_COUNT   = 16,
    parameter int unsigned UNLOCK_COUNT = 4,
    parameter int unsigned ERR_W        = 32,
    parameter int unsigned CNT_W        = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [PRBS_W-1:0] data_in,
    input  logic              data_valid,
    output logic              locked,
    output logic              err_word,
    output logic [ERR_W-1:0]  bit_err_cnt,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int unsigned HIST_W  = PRBS7_TAP_A;
    localparam int unsigned RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

    // Stage 0: combinational prediction
    logic [HIST_W-1:0]        hist;
    logic                     hist_ok;
    logic [PRBS_W+HIST_W-1:0] x;
    logic [PRBS_W-1:0]        e_comb;

    always_comb begin
        x = {data_in, hist};
        for (int unsigned i = 0; i < PRBS_W; i++) begin
            e_comb[i] = data_in[i] ^ x[i + HIST_W - PRBS7_TAP_A] ^ x[i + HIST_W - PRBS7_TAP_B];
        end
    end

    // Stage 1
    logic [PRBS_W-1:0] e1;
    logic              chk_v1;
    logic              err_any1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist     <= '0;
            hist_ok  <= 1'b0;
            e1       <= '0;
            chk_v1   <= 1'b0;
            err_any1 <= 1'b0;
        end else begin
            e1       <= e_comb;
            chk_v1   <= data_valid & hist_ok;
            err_any1 <= |e_comb;
            if (data_valid) begin
                hist    <= data_in[PRBS_W-1 -: HIST_W];
                hist_ok <= 1'b1;
            end
        end
    end

    // Stage 2
    logic [POP_W-1:0] pop;
    logic             chk_v2;
    logic             cnt_en2;

    prbs_popcount32 u_popcount (
        .clk   (clk),
        .rst_n (rst_n),
        .vec   (e1),
        .cnt   (pop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_v2   <= 1'b0;
            cnt_en2  <= 1'b0;
            err_word <= 1'b0;
        end else begin
            chk_v2   <= chk_v1;
            cnt_en2  <= locked;
            err_word <= chk_v1 & err_any1;
        end
    end

    // Lock FSM, fed by the stage-1 verdict
    state_t           state_q, state_d;
    logic [RUN_W-1:0] good_run, good_d;
    logic [RUN_W-1:0] bad_run, bad_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            good_run <= '0;
            bad_run  <= '0;
        end else begin
            state_q  <= state_d;
            good_run <= good_d;
            bad_run  <= bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_run;
        bad_d   = bad_run;
        if (chk_v1) begin
            unique case (state_q)
                HUNT: begin
                    if (err_any1) begin
                        good_d = '0;
                    end else if (good_run == RUN_W'(LOCK_COUNT - 1)) begin
                        state_d = LOCKED;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        good_d = good_run + RUN_W'(1);
                        bad_d  = '0;
                    end
                end
                LOCKED: begin
                    if (!err_any1) begin
                        bad_d = '0;
                    end else if (bad_run == RUN_W'(UNLOCK_COUNT - 1)) begin
                        state_d = HUNT;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_run + RUN_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign locked = (state_q == LOCKED);

    // Stage 3: saturating counters; clear beats a same-cycle increment
    logic [ERR_W:0] err_sum;

    always_comb begin
        err_sum = {1'b0, bit_err_cnt} + {{(ERR_W + 1 - POP_W){1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_err_cnt <= '0;
            word_cnt    <= '0;
        end else if (clear) begin
            bit_err_cnt <= '0;
            word_cnt    <= '0;
        end else if (chk_v2 && cnt_en2) begin
            bit_err_cnt <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
            if (word_cnt != '1) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a vector table for lock/error behaviour plus
// sequences for clear, asynchronous reset, gapped input and counter saturation.
module tb_prbs_checker;

    localparam int OP_PRBS   = 0;
    localparam int OP_FLIP   = 1;
    localparam int OP_ONES   = 2;
    localparam int OP_RESEED = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        data_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic        locked, err_word;
    logic [31:0] bit_err_cnt;
    logic [47:0] word_cnt;
    logic        locked_s, err_word_s;
    logic [7:0]  bit_err_s, word_s;

    always #5 clk = ~clk;

    prbs_checker #(.LOCK_COUNT(16), .UNLOCK_COUNT(4), .ERR_W(32), .CNT_W(48)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .data_in(data_in), .data_valid(data_valid),
        .locked(locked), .err_word(err_word), .bit_err_cnt(bit_err_cnt), .word_cnt(word_cnt)
    );

    prbs_checker #(.LOCK_COUNT(16), .UNLOCK_COUNT(4), .ERR_W(8), .CNT_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .data_in(data_in), .data_valid(data_valid),
        .locked(locked_s), .err_word(err_word_s), .bit_err_cnt(bit_err_s), .word_cnt(word_s)
    );

    typedef struct {
        logic valid;
        int   op;
        int   arg;
        logic exp_err;
        logic exp_lock;
        int   pop;      // error bits in this word, -1 when not hand-derived
    } vec_t;

    vec_t tbl[$];
    int   cum_b[$];
    int   cum_w[$];
    bit   known[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [6:0] g_hist = '1;

    function automatic void add(input logic v, input int op, input int arg,
                                input logic er, input logic lk, input int pop);
        vec_t t;
        t.valid = v; t.op = op; t.arg = arg; t.exp_err = er; t.exp_lock = lk; t.pop = pop;
        tbl.push_back(t);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference PRBS7 source: b[n] = b[n-7] ^ b[n-6], bit 0 sent first
    task automatic next_prbs(output logic [31:0] w);
        logic [38:0] s;
        s = '0;
        s[6:0] = g_hist;
        for (int i = 0; i < 32; i++) s[i+7] = s[i] ^ s[i+1];
        w = s[38:7];
        g_hist = s[38:32];
    endtask

    task automatic drive(input logic v, input int op, input int arg);
        logic [31:0] w;
        w = 32'hDEAD_BEEF;
        if (v) begin
            case (op)
                OP_FLIP:   begin next_prbs(w); w[arg] = ~w[arg]; end
                OP_ONES:   w = '1;
                OP_RESEED: begin g_hist = '1; next_prbs(w); end
                default:   next_prbs(w);
            endcase
        end
        data_valid = v;
        data_in = w;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int  b, w, last, k, exp_w, err_seen;
        logic prev_lock, primed, ok;

        // ---------------- reset state ----------------
        repeat (2) tick();
        check("reset locked", locked, 0);
        check("reset err_word", err_word, 0);
        check("reset bit_err_cnt", bit_err_cnt, 0);
        check("reset word_cnt", word_cnt, 0);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        add(1, OP_PRBS, 0, 0, 0, 0);                            // primes history only
        for (int i = 1; i <= 16; i++) add(1, OP_PRBS, 0, 0, (i == 16), 0);
        repeat (3) add(1, OP_PRBS, 0, 0, 1, 0);
        add(1, OP_FLIP, 0, 1, 1, 3);                            // bits 0,6,7
        repeat (2) add(1, OP_PRBS, 0, 0, 1, 0);
        add(1, OP_FLIP, 31, 1, 1, 1);                           // bit 31 ...
        add(1, OP_PRBS, 0, 1, 1, 2);                            // ... then bits 5,6 next word
        add(1, OP_PRBS, 0, 0, 1, 0);
        add(1, OP_ONES, 0, 1, 1, -1);
        add(1, OP_ONES, 0, 1, 1, 32);
        add(1, OP_ONES, 0, 1, 1, 32);
        add(1, OP_ONES, 0, 1, 0, 32);                           // 4th errored word unlocks
        add(0, OP_PRBS, 0, 0, 0, 0);
        add(1, OP_RESEED, 0, 0, 0, 0);                          // phase right after 7 ones
        add(0, OP_PRBS, 0, 0, 0, 0);
        for (int i = 2; i <= 16; i++) add(1, OP_PRBS, 0, 0, (i == 16), 0);
        add(0, OP_PRBS, 0, 0, 1, 0);
        repeat (2) add(1, OP_PRBS, 0, 0, 1, 0);

        b = 0; w = 0; ok = 1; prev_lock = 0; primed = 0;
        foreach (tbl[i]) begin
            if (tbl[i].valid && primed && prev_lock) begin
                w++;
                if (tbl[i].pop < 0) ok = 0; else b += tbl[i].pop;
            end
            if (tbl[i].valid) primed = 1;
            prev_lock = tbl[i].exp_lock;
            cum_b.push_back(b);
            cum_w.push_back(w);
            known.push_back(ok);
        end

        for (int i = 0; i <= tbl.size() + 1; i++) begin
            if (i < tbl.size()) drive(tbl[i].valid, tbl[i].op, tbl[i].arg);
            else drive(0, OP_PRBS, 0);
            tick();
            if (i >= 1 && i <= tbl.size()) begin
                check($sformatf("vec%0d err_word", i - 1), err_word, tbl[i-1].exp_err);
                check($sformatf("vec%0d locked", i - 1), locked, tbl[i-1].exp_lock);
            end
            if (i >= 2 && known[i-2]) begin
                check($sformatf("vec%0d bit_err_cnt", i - 2), bit_err_cnt, cum_b[i-2]);
                check($sformatf("vec%0d word_cnt", i - 2), word_cnt, cum_w[i-2]);
            end
        end
        last = cum_w[tbl.size() - 1];
        check("table final word_cnt", word_cnt, last);

        // ---------------- clear vs. same-cycle increment ----------------
        repeat (3) begin drive(1, OP_PRBS, 0); tick(); end
        check("pre-clear word_cnt", word_cnt, last + 1);
        clear = 1'b1;
        drive(1, OP_PRBS, 0);
        tick();
        clear = 1'b0;
        check("clear word_cnt", word_cnt, 0);
        check("clear bit_err_cnt", bit_err_cnt, 0);
        drive(1, OP_PRBS, 0);
        tick();
        check("post-clear word_cnt", word_cnt, 1);
        drive(1, OP_PRBS, 0);
        tick();
        check("post-clear word_cnt+1", word_cnt, 2);
        check("post-clear locked", locked, 1);

        // ---------------- asynchronous reset mid-stream ----------------
        rst_n = 1'b0;
        #1;
        check("async locked", locked, 0);
        check("async err_word", err_word, 0);
        check("async bit_err_cnt", bit_err_cnt, 0);
        check("async word_cnt", word_cnt, 0);
        check("async sat word_cnt", word_s, 0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        // ---------------- gapped clean stream ----------------
        k = 0; exp_w = 0; err_seen = 0; primed = 0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                drive(1, OP_PRBS, 0);
                if (primed) begin
                    k++;
                    if (k > 16) exp_w++;
                end
                primed = 1;
            end else begin
                drive(0, OP_PRBS, 0);
            end
            tick();
            if (err_word) err_seen++;
        end
        drive(0, OP_PRBS, 0);
        repeat (4) begin tick(); if (err_word) err_seen++; end
        check("gapped err_word pulses", err_seen, 0);
        check("gapped locked", locked, (k >= 16));
        check("gapped word_cnt", word_cnt, exp_w);
        check("gapped bit_err_cnt", bit_err_cnt, 0);

        // ---------------- saturation ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        err_seen = 0;
        repeat (17) begin drive(1, OP_PRBS, 0); tick(); end
        repeat (90) begin
            drive(1, OP_FLIP, 0); tick(); if (err_word) err_seen++;
            drive(1, OP_PRBS, 0); tick(); if (err_word) err_seen++;
        end
        repeat (100) begin drive(1, OP_PRBS, 0); tick(); if (err_word) err_seen++; end
        drive(0, OP_PRBS, 0);
        repeat (4) begin tick(); if (err_word) err_seen++; end
        check("sat err_word pulses", err_seen, 90);
        check("sat locked", locked, 1);
        check("sat wide bit_err_cnt", bit_err_cnt, 270);
        check("sat wide word_cnt", word_cnt, 280);
        check("sat narrow bit_err_cnt", bit_err_s, 8'hFF);
        check("sat narrow word_cnt", word_s, 8'hFF);
        check("sat narrow locked", locked_s, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
